// File: rtl/axi_read_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_typedefs (package)
// Brief  : Shared AXI4 types, response codes and the illegal-burst rule.
// Rev    : 1.0
// ============================================================================
package axi_typedefs;

  localparam int AXI_ID_W       = 4;
  localparam int AXI_ADDR_W     = 32;
  localparam int AXI_DATA_W     = 32;
  localparam int AXI_BYTES_LOG2 = $clog2(AXI_DATA_W / 8);

  typedef logic [AXI_ID_W-1:0]   axi_id_t;
  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [1:0]            axi_resp_t;

  typedef enum logic [1:0] {
    AXI_FIXED = 2'b00,
    AXI_INCR  = 2'b01,
    AXI_WRAP  = 2'b10,
    AXI_RSVD  = 2'b11
  } axi_burst_e;

  localparam axi_resp_t AXI_OKAY   = 2'b00;
  localparam axi_resp_t AXI_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  // Burst-wide errors: oversize beats, reserved burst type, WRAP of a non-power-of-2 length.
  function automatic logic axi_burst_illegal(input logic [2:0] size,
                                             input logic [3:0] len,
                                             input logic [1:0] burst);
    logic w_wrap_len_ok;
    w_wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (size > 3'(AXI_BYTES_LOG2)) ||
           (burst == 2'b11) ||
           ((burst == 2'b10) && !w_wrap_len_ok);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_read_slave_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : axi_burst_addr_gen
// Brief  : Combinational AXI next-beat address and illegal-burst detection.
// Rev    : 1.0
// ============================================================================
module axi_burst_addr_gen
  import axi_typedefs::*;
(
  input  axi_addr_t  i_addr,
  input  logic [2:0] i_size,
  input  logic [3:0] i_len,
  input  logic [1:0] i_burst,
  output axi_addr_t  o_next_addr,
  output logic       o_burst_err
);

  axi_addr_t w_sz;
  axi_addr_t w_aligned;
  axi_addr_t w_step;
  axi_addr_t w_blen;
  axi_addr_t w_base;

  always_comb begin
    w_sz      = axi_addr_t'(1) << i_size;
    w_aligned = i_addr & ~(w_sz - axi_addr_t'(1));
    w_step    = w_aligned + w_sz;
    w_blen    = (axi_addr_t'(i_len) + axi_addr_t'(1)) << i_size;
    w_base    = i_addr & ~(w_blen - axi_addr_t'(1));
    o_next_addr = i_addr;
    case (axi_burst_e'(i_burst))
      AXI_INCR: o_next_addr = w_step;
      AXI_WRAP: o_next_addr = (w_step == (w_base + w_blen)) ? w_base : w_step;
      default:  o_next_addr = i_addr;
    endcase
    o_burst_err = axi_burst_illegal(i_size, i_len, i_burst);
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_slave.sv
`default_nettype none
// ============================================================================
// Module : axi_read_slave
// Brief  : AXI4 read slave serving FIXED/INCR/WRAP bursts from a local memory.
// Rev    : 1.0
// ============================================================================
module axi_read_slave
  import axi_typedefs::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  axi_id_t                      ARID,
  input  axi_addr_t                    ARADDR,
  input  logic [2:0]                   ARSIZE,
  input  logic [3:0]                   ARLEN,
  input  logic [1:0]                   ARBURST,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output axi_id_t                      RID,
  output axi_data_t                    RDATA,
  output axi_resp_t                    RRESP,
  output logic                         RLAST,
  output logic                         RVALID,
  input  logic                         RREADY,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  axi_data_t                    mem_wdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("axi_read_slave: only RD_LATENCY=1 is supported");
  end

  rd_state_e  r_state;
  rd_state_e  w_state_nxt;
  logic       w_ar_hs;
  logic       w_adv;

  axi_data_t  r_mem [MEM_DEPTH];
  axi_addr_t  r_addr;
  logic [2:0] r_size;
  logic [3:0] r_len;
  logic [1:0] r_burst;
  logic [3:0] r_beat_cnt;
  axi_id_t    r_rid;
  axi_data_t  r_rdata;
  axi_resp_t  r_rresp;
  logic       r_rlast;

  axi_addr_t        w_next_addr;
  logic             w_gen_err;
  axi_addr_t        w_beat_addr;
  logic             w_beat_err;
  logic [IDX_W-1:0] w_beat_idx;
  axi_data_t        w_beat_data;
  logic [3:0]       w_cnt_nxt;

  axi_burst_addr_gen u_addr_gen (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr),
    .o_burst_err (w_gen_err)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= RD_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ar_hs     = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (ARVALID) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RREADY) begin
          if (r_rlast) w_state_nxt = RD_IDLE;
          else         w_adv       = 1'b1;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Beat 0 comes straight from the AR channel; later beats from the address generator.
  always_comb begin
    w_beat_addr = w_ar_hs ? ARADDR : w_next_addr;
    w_beat_idx  = w_beat_addr[AXI_BYTES_LOG2 +: IDX_W];
    w_beat_err  = (w_ar_hs ? axi_burst_illegal(ARSIZE, ARLEN, ARBURST) : w_gen_err) ||
                  (|(w_beat_addr >> (AXI_BYTES_LOG2 + IDX_W)));
    w_beat_data = w_beat_err ? '0 : r_mem[w_beat_idx];
    w_cnt_nxt   = r_beat_cnt + 4'd1;
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) r_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_len      <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= AXI_OKAY;
      r_rlast    <= 1'b0;
    end else if (w_ar_hs) begin
      r_addr     <= ARADDR;
      r_size     <= ARSIZE;
      r_len      <= ARLEN;
      r_burst    <= ARBURST;
      r_beat_cnt <= '0;
      r_rid      <= ARID;
      r_rdata    <= w_beat_data;
      r_rresp    <= w_beat_err ? AXI_SLVERR : AXI_OKAY;
      r_rlast    <= (ARLEN == 4'd0);
    end else if (w_adv) begin
      r_addr     <= w_next_addr;
      r_beat_cnt <= w_cnt_nxt;
      r_rdata    <= w_beat_data;
      r_rresp    <= w_beat_err ? AXI_SLVERR : AXI_OKAY;
      r_rlast    <= (w_cnt_nxt == r_len);
    end
  end

  assign ARREADY = (r_state == RD_IDLE);
  assign RVALID  = (r_state == RD_DATA);
  assign RID     = r_rid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_read_slave
// Brief  : Scoreboard bench for axi_read_slave with a behavioural burst model.
// Rev    : 1.0
// ============================================================================
module tb_axi_read_slave;
  import axi_typedefs::*;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  axi_id_t    ARID;
  axi_addr_t  ARADDR;
  logic [2:0] ARSIZE;
  logic [3:0] ARLEN;
  logic [1:0] ARBURST;
  logic       ARVALID;
  logic       ARREADY;
  axi_id_t    RID;
  axi_data_t  RDATA;
  axi_resp_t  RRESP;
  logic       RLAST;
  logic       RVALID;
  logic       RREADY;
  logic       mem_we;
  logic [7:0] mem_waddr;
  axi_data_t  mem_wdata;

  beat_t       exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pops     = 0;
  int          rr_mode  = 0;

  axi_read_slave #(.MEM_DEPTH(DEPTH), .RD_LATENCY(1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARSIZE(ARSIZE), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: beat addresses derived from burst slots, not from an iterative next-address.
  function automatic void push_burst(input logic [3:0] id, input logic [31:0] addr,
                                     input logic [2:0] size, input logic [3:0] len,
                                     input logic [1:0] burst);
    longint unsigned nb, nbeats, a, blen, base, slot, word;
    bit legal;
    beat_t e;
    nb     = 64'd1 << size;
    nbeats = longint'(len) + 1;
    legal  = (size <= 3'd2) && (burst != 2'b11) &&
             !((burst == 2'b10) && !(nbeats == 2 || nbeats == 4 || nbeats == 8 || nbeats == 16));
    for (int b = 0; b < int'(nbeats); b++) begin
      if (b == 0 || burst == 2'b00) a = addr;
      else if (burst == 2'b01) a = ((addr / nb) * nb + longint'(b) * nb) % 64'h1_0000_0000;
      else begin
        blen = nbeats * nb;
        base = addr - (addr % blen);
        slot = (addr % blen) / nb;
        a    = base + ((slot + longint'(b)) % nbeats) * nb;
      end
      word   = a / 4;
      e.id   = id;
      e.last = (b == int'(nbeats) - 1);
      if (legal && word < DEPTH) begin
        e.resp = AXI_OKAY;
        e.data = ref_mem[word];
      end else begin
        e.resp = AXI_SLVERR;
        e.data = 32'h0;
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] len, input logic [1:0] burst);
    bit hs;
    hs = 1'b0;
    push_burst(id, addr, size, len, burst);
    @(posedge ACLK); #1;
    ARID = id; ARADDR = addr; ARSIZE = size; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge ACLK) hs = ARREADY;
      @(posedge ACLK);
      if (hs) break;
    end
    #1 ARVALID = 1'b0;
    if (!hs) chk("ar_handshake_timeout", 32'(hs), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      if (exp_q.size() == 0 && ARREADY && !RVALID) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic write_mem(input int idx, input logic [31:0] val);
    @(posedge ACLK); #1;
    mem_we = 1'b1; mem_waddr = 8'(idx); mem_wdata = val;
    ref_mem[idx] = val;
    @(posedge ACLK); #1 mem_we = 1'b0;
  endtask

  initial begin
    RREADY = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      case (rr_mode)
        0:       RREADY = 1'b1;
        1:       RREADY = !RREADY;
        default: RREADY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every presented beat with the queue head; pop only on handshake.
  initial begin
    beat_t e;
    forever begin
      @(negedge ACLK);
      if (ARESETn && RVALID) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got rdata=%h rid=%h, required no beat", RDATA, RID);
        end else begin
          e = exp_q[0];
          chk("rdata", RDATA, e.data);
          chk("rresp", 32'(RRESP), 32'(e.resp));
          chk("rlast", 32'(RLAST), 32'(e.last));
          chk("rid", 32'(RID), 32'(e.id));
          if (RREADY) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    int base;
    bit reached;
    logic [31:0] a;
    logic [2:0]  sz;
    ARESETn = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARSIZE = '0; ARLEN = '0; ARBURST = '0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    #2;
    chk("reset_arready", 32'(ARREADY), 32'd1);
    chk("reset_rvalid", 32'(RVALID), 32'd0);
    chk("reset_rlast", 32'(RLAST), 32'd0);
    chk("reset_rid", 32'(RID), 32'd0);
    chk("reset_rdata", RDATA, 32'd0);
    chk("reset_rresp", 32'(RRESP), 32'(AXI_OKAY));
    repeat (3) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1'b1;

    for (int i = 0; i < DEPTH; i++) write_mem(i, 32'(i));

    rr_mode = 0;
    send_ar(4'd1, 32'h10, 3'd2, 4'd0, 2'b01); wait_idle();
    rr_mode = 1;
    send_ar(4'd2, 32'h00, 3'd2, 4'd3, 2'b01); wait_idle();
    rr_mode = 0;
    send_ar(4'd3, 32'h08, 3'd2, 4'd3, 2'b10); wait_idle();
    send_ar(4'd4, 32'h0C, 3'd2, 4'd2, 2'b00); wait_idle();
    send_ar(4'd5, 32'((DEPTH - 1) * 4), 3'd2, 4'd1, 2'b01); wait_idle();
    send_ar(4'd6, 32'h00, 3'd2, 4'd2, 2'b10); wait_idle();

    // Backdoor write to word 5 on the same edge that reads it: old data must come back.
    @(posedge ACLK); #1;
    push_burst(4'd7, 32'h14, 3'd2, 4'd0, 2'b01);
    ARID = 4'd7; ARADDR = 32'h14; ARSIZE = 3'd2; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    mem_we = 1'b1; mem_waddr = 8'd5; mem_wdata = 32'hA5A5_0005;
    @(posedge ACLK); #1;
    ARVALID = 1'b0; mem_we = 1'b0; ref_mem[5] = 32'hA5A5_0005;
    wait_idle();
    send_ar(4'd8, 32'h14, 3'd2, 4'd0, 2'b01); wait_idle();

    // Reset in the middle of beat 2 of an 8-beat burst.
    base = pops;
    reached = 1'b0;
    send_ar(4'd9, 32'h00, 3'd2, 4'd7, 2'b01);
    for (int c = 0; c < 200; c++) begin
      @(posedge ACLK);
      if (pops >= base + 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("reached_beat2", 32'(reached), 32'd1);
    #1 ARESETn = 1'b0;
    exp_q.delete();
    #1 chk("async_rvalid_drop", 32'(RVALID), 32'd0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_reset_rvalid", 32'(RVALID), 32'd0);
    chk("post_reset_arready", 32'(ARREADY), 32'd1);
    send_ar(4'd10, 32'h20, 3'd2, 4'd3, 2'b01); wait_idle();

    rr_mode = 2;
    for (int i = 0; i < DEPTH; i++) write_mem(i, $urandom);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           a = 32'($urandom_range(0, DEPTH * 4 + 63));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      send_ar(4'(k), a, sz, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
